serial_adder: RTL and testbench

- Bit-serial N-bit adder that processes one bit per clock, LSB first.
- Built around a single full-adder cell plus a registered carry, so it trades latency for area.
- Sits as the control/datapath stage around the full-adder cell: it feeds the cell one operand bit pair per cycle and consumes the sum/carry the cell produces.
- Presents a start/busy/done handshake to its requester.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_fa_bit.sv | 18 +
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings.
package serial_adder_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_SHIFT = 2'd1;
    localparam logic [1:0] ENC_DONE  = 2'd2;

    // 2'd3 is unused and recovers to IDLE in the controller.
    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        SHIFT = ENC_SHIFT,
        DONE  = ENC_DONE
    } state_e;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational 1-bit full adder built from two half-adder stages.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    assign ha1_s = a ^ b;
    assign ha1_c = a & b;
    assign sum   = ha1_s ^ c;
    assign ha2_c = ha1_s & c;
    assign carry = ha1_c | ha2_c;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a carry flop.
//   state | meaning
//   IDLE  | waiting for start, last result held on sum/cout
//   SHIFT | one operand bit pair added per clock
//   DONE  | result valid, done pulse, returns to IDLE
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-2:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   sum_next;

    fa_bit u_fa (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c     (carry_q),
        .sum   (fa_s),
        .carry (fa_c)
    );

    // The new bit enters at the MSB; the final value includes the last bit.
    assign sum_next = {fa_s, sum_sr_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = sum_next[WIDTH-1:1];
                carry_d  = fa_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    sum_d   = sum_next;
                    cout_d  = fa_c;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=4.
module tb_serial_adder;
    logic       clk;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int total;
    int bad;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one WIDTH=8 op; n is the edge count from the accepting edge (1) to done.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int n);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 1;
        check("busy_after_accept8", {31'd0, busy8}, 32'd1);
        while (done8 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                        output int n);
        a4 = av; b4 = bv; cin4 = cv; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 1;
        while (done4 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int n_done;
        int first_done;
        int second_done;
        logic [3:0] ra, rb;
        logic       rc;
        logic [4:0] exp5;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        tick();
        tick();
        check("reset_busy", {31'd0, busy8}, 32'd0);
        check("reset_done", {31'd0, done8}, 32'd0);
        check("reset_sum_cout", {23'd0, cout8, sum8}, 32'h000);
        rst_n = 1'b1;
        tick();

        // Carry ripple through all bits.
        run8(8'hFF, 8'h01, 1'b0, n);
        check("ripple_latency", n, 32'd9);
        check("ripple_result", {23'd0, cout8, sum8}, 32'h100);
        tick();
        check("ripple_done_one_cycle", {31'd0, done8}, 32'd0);
        check("ripple_busy_low", {31'd0, busy8}, 32'd0);

        // Carry-in, with a start pulse and operand change during SHIFT.
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        n_done = 0;
        first_done = 0;
        for (int k = 2; k <= 14; k++) begin
            start8 = (k == 4);
            tick();
            if (done8 === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (k <= 8) begin
                check("hold_prev_result", {23'd0, cout8, sum8}, 32'h100);
                check("busy_during_shift", {31'd0, busy8}, 32'd1);
            end
            if (k == 9) check("busy_in_done", {31'd0, busy8}, 32'd1);
            if (k == 10) check("busy_after_done", {31'd0, busy8}, 32'd0);
        end
        start8 = 1'b0;
        check("cin_latency", first_done, 32'd9);
        check("single_done_pulse", n_done, 32'd1);
        check("cin_result", {23'd0, cout8, sum8}, 32'h097);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        tick();
        tick();
        check("result_held", {23'd0, cout8, sum8}, 32'h097);

        // Reset in the middle of an operation.
        run8(8'hFF, 8'hFF, 1'b1, n);
        check("pre_reset_result", {23'd0, cout8, sum8}, 32'h1FF);
        tick();
        a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", {31'd0, busy8}, 32'd0);
        check("async_reset_done", {31'd0, done8}, 32'd0);
        check("async_reset_result", {23'd0, cout8, sum8}, 32'h000);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("no_done_after_abort", {31'd0, done8}, 32'd0);
        end
        run8(8'h01, 8'h01, 1'b0, n);
        check("post_reset_latency", n, 32'd9);
        check("post_reset_result", {23'd0, cout8, sum8}, 32'h002);
        tick();

        // Back-to-back with start held high.
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1;
        first_done = 0;
        second_done = 0;
        n_done = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done8 === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = k;
                else second_done = k;
            end
        end
        start8 = 1'b0;
        tick();
        check("b2b_first_done", first_done, 32'd9);
        check("b2b_done_spacing", second_done - first_done, 32'd10);
        check("b2b_done_count", n_done, 32'd2);
        check("b2b_result", {23'd0, cout8, sum8}, 32'h101);
        check("b2b_idle", {31'd0, busy8}, 32'd0);

        // WIDTH=4 directed and random.
        run4(4'hF, 4'hF, 1'b1, n);
        check("w4_latency", n, 32'd5);
        check("w4_result", {27'd0, cout4, sum4}, 32'h1F);
        tick();
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            exp5 = 5'(ra) + 5'(rb) + 5'(rc);
            run4(ra, rb, rc, n);
            check("w4_rand_latency", n, 32'd5);
            check("w4_rand_result", {27'd0, cout4, sum4}, {27'd0, exp5});
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
